// File: rtl/conv_frame_sched.sv
// conv_frame_sched: streams one FxF frame from image RAM into the 3x3 window generator.
// Define CONV_SCHED_STALL_CNT_EN to build the credit-stall cycle counter on o_stall_cnt.
module conv_frame_sched #(
    parameter int F  = 28,
    parameter int B  = 8,
    parameter int LB = 4,
    parameter int AW = $clog2(F*F)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_win_rst,
    output logic                   o_mem_rd_en,
    output logic [AW-1:0]          o_mem_addr,
    input  logic [B-1:0]           i_mem_rd_data,
    output logic [B-1:0]           o_pixel_data,
    output logic                   o_pixel_data_valid,
    input  logic                   i_intr,
    output logic [$clog2(F+1)-1:0] o_row_cnt,
    output logic [15:0]            o_stall_cnt
);

    localparam int CLW = $clog2(F);
    localparam int RW  = $clog2(F+1);
    localparam int CRW = $clog2(LB+1);

    localparam logic [CLW-1:0] COL_LAST  = CLW'(F-1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(F-1);
    localparam logic [RW-1:0]  INTR_DONE = RW'(F-2);
    localparam logic [RW-1:0]  INTR_MAX  = '1;
    localparam logic [CRW-1:0] CRED_MAX  = CRW'(LB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_win_rst;
    logic           r_rd_en;
    logic           r_pix_valid;
    logic [AW-1:0]  r_addr;
    logic [CLW-1:0] r_col;
    logic [RW-1:0]  r_row;
    logic [RW-1:0]  r_intr_cnt;
    logic [CRW-1:0] r_credits;

    logic           w_row_end;
    logic           w_intr_live;
    logic [CRW-1:0] w_credit_nxt;

    assign w_row_end   = (r_state == S_STREAM) && (r_col == COL_LAST);
    assign w_intr_live = i_intr && (r_state != S_IDLE);

    // A row-done returning in the same cycle as a row-end spend cancels out.
    always_comb begin
        w_credit_nxt = r_credits;
        if (w_row_end && !w_intr_live) begin
            w_credit_nxt = r_credits - 1'b1;
        end else if (!w_row_end && w_intr_live && r_credits != CRED_MAX) begin
            w_credit_nxt = r_credits + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_win_rst   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_intr_cnt  <= '0;
            r_credits   <= CRED_MAX;
        end else begin
            r_pix_valid <= r_rd_en;
            r_credits   <= w_credit_nxt;
            if (w_intr_live && r_intr_cnt != INTR_MAX) begin
                r_intr_cnt <= r_intr_cnt + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state    <= S_CLR;
                        r_busy     <= 1'b1;
                        r_win_rst  <= 1'b1;
                        r_addr     <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_intr_cnt <= '0;
                        r_credits  <= CRED_MAX;
                    end
                end
                S_CLR: begin
                    r_win_rst <= 1'b0;
                    r_rd_en   <= 1'b1;
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    r_addr <= r_addr + 1'b1;
                    if (w_row_end) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                        if (r_row == ROW_LAST) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_DRAIN;
                        end else if (w_credit_nxt == '0) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_credits != '0) begin
                        r_rd_en <= 1'b1;
                        r_state <= S_STREAM;
                    end
                end
                // Unpadded 3x3 windows give F-2 window rows per frame.
                S_DRAIN: begin
                    if (r_intr_cnt >= INTR_DONE) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_WAIT && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_win_rst          = r_win_rst;
    assign o_mem_rd_en        = r_rd_en;
    assign o_mem_addr         = r_addr;
    assign o_pixel_data       = i_mem_rd_data;
    assign o_pixel_data_valid = r_pix_valid;
    assign o_row_cnt          = r_row;

endmodule

// File: tb/tb_conv_frame_sched.sv
// tb_conv_frame_sched: directed vectors and frame sequences for conv_frame_sched.
// Includes a RAM model and a row-done generator model.
module tb_conv_frame_sched;

    localparam int F  = 28;
    localparam int B  = 8;
    localparam int LB = 4;
    localparam int AW = 10;
    localparam int RW = 5;
`ifdef CONV_SCHED_STALL_CNT_EN
    localparam int STALL_ON = 1;
`else
    localparam int STALL_ON = 0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start    = 1'b0;
    logic          man_intr = 1'b0;
    logic          gen_en   = 1'b0;
    logic          gen_intr = 1'b0;
    logic          intr;
    logic [B-1:0]  ram_q    = '0;

    logic          o_busy;
    logic          o_done;
    logic          o_win_rst;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_addr;
    logic [B-1:0]  o_pixel_data;
    logic          o_pixel_data_valid;
    logic [RW-1:0] o_row_cnt;
    logic [15:0]   o_stall_cnt;

    int total = 0;
    int bad   = 0;

    assign intr = gen_en ? gen_intr : man_intr;

    conv_frame_sched #(.F(F), .B(B), .LB(LB), .AW(AW)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_win_rst         (o_win_rst),
        .o_mem_rd_en       (o_mem_rd_en),
        .o_mem_addr        (o_mem_addr),
        .i_mem_rd_data     (ram_q),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid),
        .i_intr            (intr),
        .o_row_cnt         (o_row_cnt),
        .o_stall_cnt       (o_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [B-1:0] pat(input int a);
        return 8'((a * 37 + 11) % 251);
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_busy"}, 32'(o_busy), 0);
        check({nm, "_done"}, 32'(o_done), 0);
        check({nm, "_winrst"}, 32'(o_win_rst), 0);
        check({nm, "_rden"}, 32'(o_mem_rd_en), 0);
        check({nm, "_addr"}, 32'(o_mem_addr), 0);
        check({nm, "_valid"}, 32'(o_pixel_data_valid), 0);
        check({nm, "_row"}, 32'(o_row_cnt), 0);
        check({nm, "_stall"}, 32'(o_stall_cnt), 0);
    endtask

    always @(posedge clk) begin
        if (o_mem_rd_en) ram_q <= pat(int'(o_mem_addr));
    end

    int cyc = 0, rd_cnt = 0, pix_cnt = 0, done_cnt = 0, wr_cnt = 0;
    int first_rd = 0, last_rd = 0, intr_seen = 0;

    always @(negedge clk) begin
        cyc++;
        gen_intr = 1'b0;
        if (o_win_rst) begin
            wr_cnt++;
            rd_cnt   = 0;
            pix_cnt  = 0;
            done_cnt = 0;
        end
        if (o_mem_rd_en) begin
            check("rd_addr", 32'(o_mem_addr), rd_cnt);
            if (rd_cnt == 0) first_rd = cyc;
            last_rd = cyc;
            rd_cnt++;
        end
        if (o_pixel_data_valid) begin
            check("pixel", 32'(o_pixel_data), 32'(pat(pix_cnt)));
            if (pix_cnt % F == F-1 && pix_cnt / F >= 2) gen_intr = 1'b1;
            pix_cnt++;
        end
        if (o_done) done_cnt++;
    end

    always @(posedge clk) begin
        if (o_win_rst) intr_seen = 0;
        else if (intr && o_busy) intr_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          start;
        logic          intr;
        logic          busy;
        logic          win_rst;
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          valid;
    } vec_t;

    vec_t vt[7];
    int   k;
    int   wr0;

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd1, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd2, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd3, 1'b1};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd4, 1'b1};

        #1 rst_n = 1'b0;
        #1 check_idle("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start    = vt[i].start;
            man_intr = vt[i].intr;
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(vt[i].busy));
            check($sformatf("vec%0d_winrst", i), 32'(o_win_rst), 32'(vt[i].win_rst));
            check($sformatf("vec%0d_rden", i), 32'(o_mem_rd_en), 32'(vt[i].rd_en));
            check($sformatf("vec%0d_addr", i), 32'(o_mem_addr), 32'(vt[i].addr));
            check($sformatf("vec%0d_valid", i), 32'(o_pixel_data_valid), 32'(vt[i].valid));
        end
        start    = 1'b0;
        man_intr = 1'b0;

        k = 0;
        while (o_mem_rd_en && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("nocredit_stop", 32'(o_mem_rd_en), 0);
        check("nocredit_reads", rd_cnt, LB * F);
        check("nocredit_busy", 32'(o_busy), 1);
        check("nocredit_rows", 32'(o_row_cnt), LB);
        check("stall_first", 32'(o_stall_cnt), 0);
        repeat (5) @(negedge clk);
        check("stall_5", 32'(o_stall_cnt), STALL_ON * 5);
        check("wait_hold", 32'(o_mem_rd_en), 0);

        man_intr = 1'b1;
        @(negedge clk);
        man_intr = 1'b0;
        check("credit_lat_n", 32'(o_mem_rd_en), 0);
        @(negedge clk);
        check("credit_lat_n1", 32'(o_mem_rd_en), 1);
        check("credit_addr", 32'(o_mem_addr), LB * F);

        k = 0;
        while (!(o_mem_rd_en && o_mem_addr == 10'd139) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_139", 32'(o_mem_addr), 139);
        man_intr = 1'b1;
        @(negedge clk);
        man_intr = 1'b0;
        check("coinc_rden", 32'(o_mem_rd_en), 1);
        check("coinc_addr", 32'(o_mem_addr), 140);
        check("coinc_row", 32'(o_row_cnt), 5);
        k = 0;
        while (o_mem_rd_en && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("coinc_stop", 32'(o_mem_rd_en), 0);
        check("coinc_reads", rd_cnt, 168);
        check("coinc_rows", 32'(o_row_cnt), 6);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("reset_wait");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(o_mem_rd_en && o_mem_addr == 10'd50) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_50", 32'(o_mem_addr), 50);
        #2 rst_n = 1'b0;
        #1 check_idle("reset_midrow");

        @(negedge clk);
        rst_n    = 1'b1;
        man_intr = 1'b1;
        @(negedge clk);
        man_intr = 1'b0;
        gen_en   = 1'b1;
        wr0      = wr_cnt;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_winrst", 32'(o_win_rst), 1);
        check("restart_row", 32'(o_row_cnt), 0);
        check("restart_addr", 32'(o_mem_addr), 0);
        k = 0;
        while (!(o_mem_rd_en && o_mem_addr == 10'd300) && k < 400) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!o_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("frame_done", 32'(o_done), 1);
        check("frame_busy_at_done", 32'(o_busy), 1);
        check("frame_reads", rd_cnt, F * F);
        check("frame_rows", 32'(o_row_cnt), F);
        check("frame_intrs", intr_seen, F - 2);
        @(negedge clk);
        check("busy_fall", 32'(o_busy), 0);
        check("done_pulse", 32'(o_done), 0);
        repeat (5) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("pix_count", pix_cnt, F * F);
        check("read_span", last_rd - first_rd, F * F - 1);
        check("winrst_count", wr_cnt - wr0, 1);
        check("frame_stall", 32'(o_stall_cnt), 0);
        check("idle_rden", 32'(o_mem_rd_en), 0);
        check("idle_busy", 32'(o_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
